// File: rtl/cpu16_pkg.sv
// Shared CPU-16 datapath constants and types used by the register file.
package cpu16_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 2;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage : cpu16_pkg

// File: rtl/rf_reg.sv
// Single register with asynchronous active-high clear and load enable.
module rf_reg #(
  parameter int WIDTH = cpu16_pkg::DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  import cpu16_pkg::*;

  logic [WIDTH-1:0] dataQ;
  logic [WIDTH-1:0] dataD;

  always_comb begin
    dataD = dataQ;
    if (load_i) begin
      dataD = d_i;
    end
  end

  // Clear wins over load, so a write coinciding with reset is discarded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dataQ <= '0;
    end else begin
      dataQ <= dataD;
    end
  end

  assign q_o = dataQ;

endmodule : rf_reg

// File: rtl/register_file.sv
// 4 x 16-bit register file: two combinational read ports, one clocked write port.
module register_file #(
  parameter int DATA_WIDTH = cpu16_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu16_pkg::ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] RS,
  input  logic [ADDR_WIDTH-1:0] RT,
  input  logic [ADDR_WIDTH-1:0] RD,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadRS,
  output logic [DATA_WIDTH-1:0] ReadRT
);

  import cpu16_pkg::*;

  localparam int NumRegs = 2 ** ADDR_WIDTH;

  logic [NumRegs-1:0]    loadEn;
  logic [DATA_WIDTH-1:0] regQ [NumRegs];

  // One-hot write-enable decode of RD, gated by RegWrite.
  always_comb begin
    loadEn = '0;
    if (RegWrite) begin
      loadEn[RD] = 1'b1;
    end
  end

  for (genvar i = 0; i < NumRegs; i++) begin : gRegs
    rf_reg #(
      .WIDTH (DATA_WIDTH)
    ) uReg (
      .clk_i  (Clock),
      .rst_i  (Reset),
      .load_i (loadEn[i]),
      .d_i    (WriteData),
      .q_o    (regQ[i])
    );
  end

  // No write bypass: reads see the stored value until the write edge.
  assign ReadRS = regQ[RS];
  assign ReadRT = regQ[RT];

endmodule : register_file

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected reads, a monitor checks them.
`timescale 1ns/1ps
module tb_register_file;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  RS = '0;
  logic [1:0]  RT = '0;
  logic [1:0]  RD = '0;
  logic [15:0] WriteData = '0;
  logic        RegWrite = 1'b0;
  logic [15:0] ReadRS;
  logic [15:0] ReadRT;

  typedef struct {
    string       name;
    logic [15:0] expRS;
    logic [15:0] expRT;
  } exp_t;

  exp_t sb [$];
  event checkEv;
  int   vectorCount = 0;
  int   missCount = 0;

  register_file dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .RS        (RS),
    .RT        (RT),
    .RD        (RD),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .ReadRS    (ReadRS),
    .ReadRT    (ReadRT)
  );

  always #10 Clock = ~Clock;

  // Monitor: samples outputs shortly after each request and pops the expectation.
  initial begin
    exp_t e;
    forever begin
      @(checkEv);
      #1;
      if (sb.size() == 0) begin
        missCount++;
        $display("[TB] FAIL scoreboard_underflow: got a check request, required a queued expectation");
      end else begin
        e = sb.pop_front();
        vectorCount += 2;
        if (ReadRS !== e.expRS) begin
          missCount++;
          $display("[TB] FAIL %s.ReadRS: got %h, required %h", e.name, ReadRS, e.expRS);
        end
        if (ReadRT !== e.expRT) begin
          missCount++;
          $display("[TB] FAIL %s.ReadRT: got %h, required %h", e.name, ReadRT, e.expRT);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] rs, input logic [1:0] rt);
    RS = rs;
    RT = rt;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expRs, input logic [15:0] expRt);
    exp_t e;
    e.name  = name;
    e.expRS = expRs;
    e.expRT = expRt;
    sb.push_back(e);
    -> checkEv;
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      #0.25;
    end
    if (sb.size() != 0) begin
      missCount++;
      $display("[TB] FAIL %s.timeout: got %0d pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Drive a write at the next rising edge, then drop RegWrite at the falling edge.
  task automatic writeReg(input logic [1:0] rd, input logic [15:0] data);
    @(negedge Clock);
    RD = rd;
    WriteData = data;
    RegWrite = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    RegWrite = 1'b0;
  endtask

  initial begin
    #1 Reset = 1'b1;
    #1;
    applyStimulus(2'd0, 2'd1);
    checkOutput("reset_hold_01", 16'h0000, 16'h0000);
    applyStimulus(2'd2, 2'd3);
    checkOutput("reset_hold_23", 16'h0000, 16'h0000);
    @(negedge Clock);
    Reset = 1'b0;

    writeReg(2'd2, 16'd1);
    writeReg(2'd3, 16'd4);
    applyStimulus(2'd2, 2'd3);
    checkOutput("basic_23", 16'd1, 16'd4);
    applyStimulus(2'd0, 2'd1);
    checkOutput("basic_untouched_01", 16'h0000, 16'h0000);

    @(negedge Clock);
    RegWrite = 1'b0;
    RD = 2'd2;
    WriteData = 16'hFFFF;
    @(posedge Clock);
    @(negedge Clock);
    applyStimulus(2'd2, 2'd3);
    checkOutput("write_disabled", 16'd1, 16'd4);

    RD = 2'd1;
    WriteData = 16'hABCD;
    RegWrite = 1'b1;
    applyStimulus(2'd1, 2'd2);
    checkOutput("rdw_before_edge", 16'h0000, 16'd1);
    @(posedge Clock);
    checkOutput("rdw_after_edge", 16'hABCD, 16'd1);
    @(negedge Clock);
    RegWrite = 1'b0;

    writeReg(2'd0, 16'h1234);
    applyStimulus(2'd0, 2'd1);
    checkOutput("reg0_writable", 16'h1234, 16'hABCD);

    writeReg(2'd3, 16'hFFFF);
    applyStimulus(2'd3, 2'd3);
    checkOutput("same_addr_ffff", 16'hFFFF, 16'hFFFF);
    applyStimulus(2'd2, 2'd0);
    checkOutput("others_undisturbed", 16'd1, 16'h1234);
    writeReg(2'd3, 16'h0000);
    applyStimulus(2'd3, 2'd3);
    checkOutput("same_addr_zero", 16'h0000, 16'h0000);

    @(negedge Clock);
    #1 Reset = 1'b1;
    applyStimulus(2'd0, 2'd1);
    checkOutput("async_reset_01", 16'h0000, 16'h0000);
    applyStimulus(2'd2, 2'd3);
    checkOutput("async_reset_23", 16'h0000, 16'h0000);
    applyStimulus(2'd1, 2'd0);
    checkOutput("async_reset_10", 16'h0000, 16'h0000);
    applyStimulus(2'd3, 2'd2);
    checkOutput("async_reset_32", 16'h0000, 16'h0000);

    @(negedge Clock);
    RD = 2'd2;
    WriteData = 16'h5555;
    RegWrite = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    RegWrite = 1'b0;
    applyStimulus(2'd2, 2'd2);
    checkOutput("reset_priority", 16'h0000, 16'h0000);
    Reset = 1'b0;
    writeReg(2'd2, 16'h5555);
    applyStimulus(2'd2, 2'd1);
    checkOutput("post_reset_write", 16'h5555, 16'h0000);

    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule : tb_register_file
